// File: rtl/uart_frame_tx_if.sv
// rtl/uart_frame_tx_if.sv - byte write port and FIFO status of uart_frame_tx
interface uart_frame_tx_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic                          wr_en;
  logic [DATA_BITS-1:0]          wr_data;
  logic                          full;
  logic                          empty;
  logic [$clog2(FIFO_DEPTH):0]   level;
  logic                          overflow;

  modport master (output wr_en, wr_data, input full, empty, level, overflow);
  modport slave  (input wr_en, wr_data, output full, empty, level, overflow);
endinterface

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - FIFO-fed serial frame generator with baud divider and parity
// Line outputs are registered from the FSM, so uart_tx trails the state by one cycle.
module uart_frame_tx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  uart_frame_tx_if.slave    bus,
  output logic              busy,
  output logic              frame_done,
  output logic              uart_tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 overflow_q;
  logic                 push, pop;

  state_t               state, state_next;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 bit_end, last_stop, tx_next, done_pend;

  assign bus.full     = (count == (AW+1)'(FIFO_DEPTH));
  assign bus.empty    = (count == '0);
  assign bus.level    = count;
  assign bus.overflow = overflow_q;
  assign push         = bus.wr_en && !bus.full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (bus.wr_en && bus.full) overflow_q <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bit_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_next = state;
    tx_next    = 1'b1;
    pop        = 1'b0;
    last_stop  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !bus.empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        tx_next = shift[0];
        if (bit_end && bit_cnt == 4'(DATA_BITS - 1))
          state_next = (PARITY_MODE != 0) ? PARITY : STOP;
      end
      PARITY: begin
        tx_next = par_bit;
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end && bit_cnt == 4'(STOP_BITS - 1)) begin
          last_stop  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // bit_cnt counts data bits in DATA and stop bits in STOP; cleared on every state change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      uart_tx    <= 1'b1;
      busy       <= 1'b0;
      done_pend  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
      if (state_next != state) bit_cnt <= '0;
      else if (bit_end)        bit_cnt <= bit_cnt + 1'b1;
      if (pop) begin
        shift   <= mem[rd_ptr];
        par_bit <= (^mem[rd_ptr]) ^ (PARITY_MODE == 2);
      end else if (state == DATA && bit_end) begin
        shift   <= shift >> 1;
      end
      uart_tx    <= tx_next;
      busy       <= (state != IDLE);
      done_pend  <= last_stop;
      frame_done <= done_pend;
    end
  end
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb/tb_uart_frame_tx.sv - randomized frame-level reference check of uart_frame_tx in three configurations
module tb_uart_frame_tx;
  localparam int N = 3;
  localparam int CPB_C [N] = '{4, 3, 2};
  localparam int DB_C  [N] = '{8, 5, 7};
  localparam int PM_C  [N] = '{0, 2, 1};
  localparam int SB_C  [N] = '{1, 2, 1};
  localparam int FD_C  [N] = '{4, 4, 8};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       en_a [N];
  logic       wr_en_a [N];
  logic [8:0] wr_data_a [N];
  logic       tx_a [N], busy_a [N], done_a [N], full_a [N], empty_a [N], ovf_a [N];
  logic [3:0] lvl_a [N];

  for (genvar g = 0; g < N; g++) begin : gen_dut
    localparam int DB = DB_C[g];
    localparam int FD = FD_C[g];
    uart_frame_tx_if #(.DATA_BITS(DB), .FIFO_DEPTH(FD)) bus ();
    assign bus.wr_en   = wr_en_a[g];
    assign bus.wr_data = wr_data_a[g][DB-1:0];
    assign full_a[g]   = bus.full;
    assign empty_a[g]  = bus.empty;
    assign ovf_a[g]    = bus.overflow;
    assign lvl_a[g]    = 4'(bus.level);
    uart_frame_tx #(
      .CLKS_PER_BIT(CPB_C[g]), .DATA_BITS(DB), .PARITY_MODE(PM_C[g]),
      .STOP_BITS(SB_C[g]), .FIFO_DEPTH(FD)
    ) dut (
      .clk(clk), .reset(rst_n), .enable(en_a[g]), .bus(bus),
      .busy(busy_a[g]), .frame_done(done_a[g]), .uart_tx(tx_a[g])
    );
  end

  // Model: a byte queue per DUT plus the expected future line, one entry per cycle
  int  q    [N][$];
  bit  wave [N][$];
  bit  jemp [N];
  bit  ovf_m [N];
  bit  exp_tx [N], exp_busy [N], exp_done [N];
  int  vectors, miscompares, edge_no;

  task automatic check(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] at edge %0d: got %0h, expected %0h", tag, idx, edge_no, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      wave[i].delete();
      jemp[i] = 0; ovf_m[i] = 0;
      exp_tx[i] = 1; exp_busy[i] = 0; exp_done[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      bit idle, full_pre, empty_pre, pop;
      int d, par;
      idle      = (wave[i].size() == 0);
      full_pre  = (q[i].size() == FD_C[i]);
      empty_pre = (q[i].size() == 0);
      pop       = idle && en_a[i] && !empty_pre;
      exp_done[i] = jemp[i];
      if (!idle) begin
        exp_tx[i]   = wave[i].pop_front();
        exp_busy[i] = 1;
        jemp[i]     = (wave[i].size() == 0);
      end else begin
        exp_tx[i] = 1; exp_busy[i] = 0; jemp[i] = 0;
      end
      d = 0;
      if (pop) d = q[i].pop_front();
      if (wr_en_a[i]) begin
        if (full_pre) ovf_m[i] = 1;
        else q[i].push_back(int'(wr_data_a[i]) & ((1 << DB_C[i]) - 1));
      end
      if (pop) begin
        par = (PM_C[i] == 2) ? 1 : 0;
        for (int c = 0; c < CPB_C[i]; c++) wave[i].push_back(1'b0);
        for (int b = 0; b < DB_C[i]; b++) begin
          par ^= (d >> b) & 1;
          for (int c = 0; c < CPB_C[i]; c++) wave[i].push_back(1'((d >> b) & 1));
        end
        if (PM_C[i] != 0)
          for (int c = 0; c < CPB_C[i]; c++) wave[i].push_back(1'(par));
        for (int c = 0; c < SB_C[i] * CPB_C[i]; c++) wave[i].push_back(1'b1);
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      check("uart_tx",    i, tx_a[i],   exp_tx[i]);
      check("busy",       i, busy_a[i], exp_busy[i]);
      check("frame_done", i, done_a[i], exp_done[i]);
      check("level",      i, lvl_a[i],  q[i].size());
      check("full",       i, full_a[i], q[i].size() == FD_C[i]);
      check("empty",      i, empty_a[i], q[i].size() == 0);
      check("overflow",   i, ovf_a[i],  ovf_m[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    edge_no++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < N; i++) begin
      wr_en_a[i] = 1'b0; wr_data_a[i] = '0;
    end
  endtask

  task automatic rand_inputs(input int wr_pct);
    for (int i = 0; i < N; i++) begin
      wr_en_a[i]   = ($urandom_range(99) < wr_pct);
      wr_data_a[i] = 9'($urandom);
    end
  endtask

  initial begin
    int n;
    vectors = 0; miscompares = 0; edge_no = 0;
    rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < N; i++) en_a[i] = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // 0xA5 written at edge 5 on the 8N1 instance
    repeat (4) step();
    wr_en_a[0] = 1'b1; wr_data_a[0] = 9'h0A5;
    step();
    wr_en_a[0] = 1'b0;
    while (edge_no < 47) begin
      step();
      if (edge_no == 6)  check("pre_start_high", 0, tx_a[0], 1);
      if (edge_no == 7)  check("start_low", 0, tx_a[0], 0);
      if (edge_no == 11) check("data_bit0", 0, tx_a[0], 1);
      if (edge_no == 15) check("data_bit1", 0, tx_a[0], 0);
      if (edge_no == 46) check("done_not_yet", 0, done_a[0], 0);
      if (edge_no == 47) check("done_edge47", 0, done_a[0], 1);
    end

    repeat (1500) begin rand_inputs(3); step(); end

    for (int i = 0; i < N; i++) en_a[i] = 1'b0;
    repeat (40) begin rand_inputs(60); step(); end
    for (int i = 0; i < N; i++) en_a[i] = 1'b1;
    repeat (1500) begin rand_inputs(50); step(); end

    repeat (2000) begin
      rand_inputs(20);
      if ($urandom_range(24) == 0) begin
        int k;
        k = $urandom_range(N - 1);
        en_a[k] = !en_a[k];
      end
      step();
    end

    // asynchronous reset landing in the third data bit of instance 0
    for (int i = 0; i < N; i++) en_a[i] = 1'b1;
    idle_inputs();
    wr_en_a[0] = 1'b1; wr_data_a[0] = 9'h0F0;
    step();
    idle_inputs();
    n = 0;
    while (!busy_a[0] && n < 400) begin step(); n++; end
    check("busy_wait", 0, busy_a[0], 1);
    repeat (3 * CPB_C[0] + 1) step();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check("rst_tx",    i, tx_a[i],   1);
      check("rst_busy",  i, busy_a[i], 0);
      check("rst_level", i, lvl_a[i],  0);
      check("rst_ovf",   i, ovf_a[i],  0);
      check("rst_done",  i, done_a[i], 0);
    end
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    repeat (30) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Parametrised serial frame generator with its own byte FIFO.
- Generalised successor to our fixed-timing UART stimulus: replaces hand-timed delays with a cycle-exact baud divider and configurable data width, parity and stop bits.
- Sits between a byte producer (CPU peripheral bus or bench sequencer) and the pipeline's uart_rx input.
- Synthesizable, so the same block serves as a bench driver and an on-board loopback source.

Parameters:
CLKS_PER_BIT, 10416, clock cycles per serial bit (≥2).
DATA_BITS, 8, data bits per frame (5..9), sent LSB first.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame (1 or 2).
FIFO_DEPTH, 16, byte FIFO entries (power of two, ≥2).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
enable  input  1  allows new frames to start; low finishes the current frame, then holds idle.
wr_en  input  1  push wr_data into FIFO this cycle.
wr_data  input  DATA_BITS  byte to transmit.
full  output  1  FIFO full.
empty  output  1  FIFO empty.
level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
overflow  output  1  sticky: set by a write while full, cleared only by reset.
busy  output  1  high while a frame is on the line.
frame_done  output  1  one-cycle pulse on the cycle after the last stop bit ends.
uart_tx  output  1  serial line, registered, idle high.

Behaviour:
- Reset (reset low, asynchronous) forces:
  - outputs: uart_tx=1, busy=0, frame_done=0, overflow=0, full=0, empty=1, level=0;
  - state IDLE, FIFO pointers 0, baud counter 0.
- Reset asserted mid-frame truncates the frame immediately; the line returns high with no glitch low.
- FIFO behaviour:
  - Write is accepted when wr_en=1 and full=0 at the edge.
  - Write when full is dropped, sets overflow, and leaves FIFO contents unchanged.
  - full and empty are evaluated before a same-cycle pop: a write in a full cycle is dropped even if a pop occurs that cycle.
  - Simultaneous write and pop when not full and not empty leaves level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- States and transitions:
  - IDLE: uart_tx=1, busy=0.
    - If enable=1 and empty=0: pop the head byte into the shift register, compute parity over the DATA_BITS data bits, go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: uart_tx=shift[0] for CLKS_PER_BIT cycles, shift right, repeat DATA_BITS times.
    - Next state: PARITY if PARITY_MODE≠0, else STOP.
  - PARITY: even mode sends the XOR of the data bits; odd mode sends its inverse. Lasts CLKS_PER_BIT cycles → STOP.
  - STOP: uart_tx=1 for STOP_BITS×CLKS_PER_BIT cycles.
    - Then pulse frame_done and return to IDLE.
- Latency and timing:
  - A write at edge k into an empty FIFO in IDLE (enable=1): pop at edge k+1, uart_tx low from edge k+2.
  - Every bit lasts exactly CLKS_PER_BIT cycles; no extra cycles between bits.
  - Back-to-back frames: the start bit of the next frame follows the last stop cycle after exactly one IDLE cycle. That cycle is high, and frame_done pulses in it.
- busy is high from the first START cycle through the last STOP cycle.
- enable deasserted mid-frame: the frame completes normally; no new pop until enable=1.
- Baud counter counts 0..CLKS_PER_BIT-1 and reloads on bit change; width $clog2(CLKS_PER_BIT).
- Frame length in cycles is (1+DATA_BITS+(PARITY_MODE≠0)+STOP_BITS)×CLKS_PER_BIT.

Test Plan:
1. CLKS_PER_BIT=4, 8N1, write 0xA5 at edge 5 → uart_tx low from edge 7 for 4 cycles, then data bits 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles; frame_done pulses once at edge 47.
2. 8E1 with 0x07, then 8O2 with 0x07 → parity bit 1 (even) / 0 (odd); 8O2 frame totals 48 cycles with stop high for 8 cycles.
3. FIFO_DEPTH=4, enable=0, write 5 bytes 0x11..0x15 → full=1 after the 4th write, 5th dropped, overflow=1, level=4. Raise enable → exactly 0x11..0x14 sent in order, one IDLE cycle between frames.
4. Drop enable during the DATA state of frame 1 with 2 bytes queued → frame 1 completes; uart_tx stays high and level stays 1 until enable returns.
5. Assert reset during the 3rd data bit → uart_tx=1 and busy=0 immediately (asynchronous); level=0, overflow=0; after release the line stays idle high.
6. DATA_BITS=5, write 0x1F when full and simultaneously pop → write dropped, overflow set, level decrements by 1.
